// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared datapath widths, MEM-stage timeout default and the
// MEM-stage state encodings used by mem_wb_stage.
package cpu_defs;

  localparam int DATA_W_DEF   = 16;
  localparam int REG_AW_DEF   = 4;
  localparam int MAX_WAIT_DEF = 8;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } mem_state_t;

  // A load returns memory data; a store (even if the load bit is also set)
  // writes back the ALU result.
  function automatic logic is_load(input logic re, input logic we);
    return re & ~we;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register.
//   clk, rst      : clock, asynchronous active-high reset (clears everything)
//   load          : capture data/dst_addr/we/hlt
//   bubble        : we=0, hlt=0; data and dst_addr hold
//   halt_bubble   : we=0, hlt=1; data and dst_addr hold
//   data..hlt     : next values
//   wb_*          : registered outputs
// With no control asserted the register holds.
module mem_wb_reg #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  logic              halt_bubble,
  input  logic [DATA_W-1:0] data,
  input  logic [REG_AW-1:0] dst_addr,
  input  logic              we,
  input  logic              hlt,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_dst_addr,
  output logic              wb_we,
  output logic              wb_hlt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_data     <= '0;
      wb_dst_addr <= '0;
      wb_we       <= 1'b0;
      wb_hlt      <= 1'b0;
    end else if (halt_bubble) begin
      wb_we  <= 1'b0;
      wb_hlt <= 1'b1;
    end else if (bubble) begin
      wb_we  <= 1'b0;
      wb_hlt <= 1'b0;
    end else if (load) begin
      wb_data     <= data;
      wb_dst_addr <= dst_addr;
      wb_we       <= we;
      wb_hlt      <= hlt;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage plus MEM/WB register.
//   Inputs from EX/MEM : aluResultIn (also address), mem_dataIn, dst_addrIn,
//                        weIn, mem_weIn, mem_reIn, hltIn
//   Data memory port   : dmem_req/dmem_wr/dmem_addr/dmem_wdata out,
//                        dmem_rdata/dmem_ack in (variable latency)
//   Pipeline control   : stall_mem (freeze upstream), mem_err (sticky timeout)
//   To WB              : wb_dataOut, wb_dst_addrOut, wb_weOut, hltOut (registered)
//
// state    | meaning
// MEM_IDLE | no access outstanding; a zero-wait access completes here
// MEM_WAIT | request issued, waiting for ack; wait_cnt counts request cycles
// MEM_ERR  | timeout; request dropped, pipeline frozen until reset
module mem_wb_stage
  import cpu_defs::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] aluResultIn,
  input  logic [DATA_W-1:0] mem_dataIn,
  input  logic [REG_AW-1:0] dst_addrIn,
  input  logic              weIn,
  input  logic              mem_weIn,
  input  logic              mem_reIn,
  input  logic              hltIn,
  output logic              dmem_req,
  output logic              dmem_wr,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall_mem,
  output logic              mem_err,
  output logic [DATA_W-1:0] wb_dataOut,
  output logic [REG_AW-1:0] wb_dst_addrOut,
  output logic              wb_weOut,
  output logic              hltOut
);

  localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  mem_state_t       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             timeout;
  logic             access;
  logic             in_err;
  logic             wb_load, wb_bubble;
  logic [DATA_W-1:0] wb_data_nxt;

  assign access = mem_reIn | mem_weIn;
  assign in_err = (state == MEM_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MEM_IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (timeout) mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout      = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (access && !dmem_ack) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          state_nxt    = MEM_IDLE;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == LAST_CNT) begin
          state_nxt = MEM_ERR;
          timeout   = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      MEM_ERR: begin
        state_nxt = MEM_ERR;
      end
      default: begin
        state_nxt    = MEM_IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // rst gates the request so an in-flight access is dropped in the same
  // cycle reset is asserted, not one edge later.
  assign dmem_req   = access & ~in_err & ~rst;
  assign dmem_wr    = mem_weIn;
  assign dmem_addr  = aluResultIn;
  assign dmem_wdata = mem_dataIn;
  assign stall_mem  = in_err | (access & ~dmem_ack & ~rst);

  assign wb_load     = ~in_err & (~access | dmem_ack);
  assign wb_bubble   = ~in_err & access & ~dmem_ack & ~timeout;
  assign wb_data_nxt = (access && dmem_ack && is_load(mem_reIn, mem_weIn))
                       ? dmem_rdata : aluResultIn;

  mem_wb_reg #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_mem_wb_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (wb_load),
    .bubble     (wb_bubble),
    .halt_bubble(timeout),
    .data       (wb_data_nxt),
    .dst_addr   (dst_addrIn),
    .we         (weIn),
    .hlt        (hltIn),
    .wb_data    (wb_dataOut),
    .wb_dst_addr(wb_dst_addrOut),
    .wb_we      (wb_weOut),
    .wb_hlt     (hltOut)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed bench for mem_wb_stage with a writeback
// scoreboard. Each cycle the expected MEM/WB contents are queued when the
// stimulus is driven and compared after the following rising edge.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] alu_in = '0;
  logic [15:0] mdata_in = '0;
  logic [3:0]  dst_in = '0;
  logic        we_in = 1'b0;
  logic        mwe_in = 1'b0;
  logic        mre_in = 1'b0;
  logic        hlt_in = 1'b0;
  logic [15:0] rdata = '0;
  logic        ack = 1'b0;

  logic        dmem_req, dmem_wr, stall_mem, mem_err, wb_we, hlt_out;
  logic [15:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  wb_dst;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dst;
    logic        we;
    logic        hlt;
    bit          chk;
  } wb_t;

  wb_t sb[$];

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(16), .REG_AW(4), .MAX_WAIT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .aluResultIn   (alu_in),
    .mem_dataIn    (mdata_in),
    .dst_addrIn    (dst_in),
    .weIn          (we_in),
    .mem_weIn      (mwe_in),
    .mem_reIn      (mre_in),
    .hltIn         (hlt_in),
    .dmem_req      (dmem_req),
    .dmem_wr       (dmem_wr),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (rdata),
    .dmem_ack      (ack),
    .stall_mem     (stall_mem),
    .mem_err       (mem_err),
    .wb_dataOut    (wb_data),
    .wb_dst_addrOut(wb_dst),
    .wb_weOut      (wb_we),
    .hltOut        (hlt_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [15:0] a, input logic [15:0] md, input logic [3:0] d,
                        input logic w, input logic mw, input logic mr, input logic h);
    alu_in = a; mdata_in = md; dst_in = d;
    we_in = w; mwe_in = mw; mre_in = mr; hlt_in = h;
  endtask

  task automatic expect_wb(input logic [15:0] d, input logic [3:0] a,
                           input logic w, input logic h, input bit c);
    wb_t e;
    e.data = d; e.dst = a; e.we = w; e.hlt = h; e.chk = c;
    sb.push_back(e);
  endtask

  // Called at posedge+1 with inputs set; checks combinational outputs
  // mid-cycle, then the MEM/WB result after the next edge.
  task automatic cycle(input string tag, input logic e_req, input logic e_wr,
                       input logic e_stall, input logic e_err);
    wb_t e;
    #4;
    check({tag, ".req"}, 32'(dmem_req), 32'(e_req));
    if (e_req) begin
      check({tag, ".wr"}, 32'(dmem_wr), 32'(e_wr));
      check({tag, ".addr"}, 32'(dmem_addr), 32'(alu_in));
      check({tag, ".wdata"}, 32'(dmem_wdata), 32'(mdata_in));
    end
    check({tag, ".stall"}, 32'(stall_mem), 32'(e_stall));
    check({tag, ".err"}, 32'(mem_err), 32'(e_err));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.sb scoreboard empty observed=none expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".wb_we"}, 32'(wb_we), 32'(e.we));
      check({tag, ".hlt"}, 32'(hlt_out), 32'(e.hlt));
      if (e.chk) begin
        check({tag, ".wb_data"}, 32'(wb_data), 32'(e.data));
        check({tag, ".wb_dst"}, 32'(wb_dst), 32'(e.dst));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req"}, 32'(dmem_req), 32'd0);
    check({tag, ".stall"}, 32'(stall_mem), 32'd0);
    check({tag, ".err"}, 32'(mem_err), 32'd0);
    check({tag, ".wb_data"}, 32'(wb_data), 32'd0);
    check({tag, ".wb_dst"}, 32'(wb_dst), 32'd0);
    check({tag, ".wb_we"}, 32'(wb_we), 32'd0);
    check({tag, ".hlt"}, 32'(hlt_out), 32'd0);
  endtask

  initial begin
    // power-on reset
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all_zero("por");
    rst = 1'b0;

    // ALU op: 1-cycle latency, no memory request
    set_in(16'h1234, 16'h0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_wb(16'h1234, 4'd3, 1'b1, 1'b0, 1'b1);
    cycle("alu", 1'b0, 1'b0, 1'b0, 1'b0);

    // halt marker passes through a non-access instruction
    set_in(16'h0007, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_wb(16'h0007, 4'd0, 1'b0, 1'b1, 1'b1);
    cycle("halt_pass", 1'b0, 1'b0, 1'b0, 1'b0);

    // zero-wait load
    set_in(16'h0040, 16'h0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    ack = 1'b1; rdata = 16'hBEEF;
    expect_wb(16'hBEEF, 4'd5, 1'b1, 1'b0, 1'b1);
    cycle("load0", 1'b1, 1'b0, 1'b0, 1'b0);

    // store acked after 3 cycles: 4 request cycles, 3 stall cycles
    set_in(16'h0010, 16'h00AA, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    ack = 1'b0; rdata = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      expect_wb(16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
      cycle("store_wait", 1'b1, 1'b1, 1'b1, 1'b0);
    end
    ack = 1'b1;
    expect_wb(16'h0010, 4'd0, 1'b0, 1'b0, 1'b1);
    cycle("store_ack", 1'b1, 1'b1, 1'b0, 1'b0);

    // load+store both set is a write; writeback gets the ALU result
    set_in(16'h0050, 16'h0055, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    ack = 1'b1; rdata = 16'hF00D;
    expect_wb(16'h0050, 4'd6, 1'b1, 1'b0, 1'b1);
    cycle("rw_both", 1'b1, 1'b1, 1'b0, 1'b0);

    // back-to-back loads: first acked after 2 cycles, second zero-wait
    set_in(16'h0020, 16'h0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    ack = 1'b0; rdata = 16'h0BAD;
    for (int i = 0; i < 2; i++) begin
      expect_wb(16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
      cycle("b2b_wait", 1'b1, 1'b0, 1'b1, 1'b0);
    end
    ack = 1'b1; rdata = 16'h1111;
    expect_wb(16'h1111, 4'd1, 1'b1, 1'b0, 1'b1);
    cycle("b2b_ld1", 1'b1, 1'b0, 1'b0, 1'b0);
    set_in(16'h0022, 16'h0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    rdata = 16'h2222;
    expect_wb(16'h2222, 4'd2, 1'b1, 1'b0, 1'b1);
    cycle("b2b_ld2", 1'b1, 1'b0, 1'b0, 1'b0);

    // ack in the final allowed cycle (8th request cycle) is accepted
    set_in(16'h0060, 16'h0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    ack = 1'b0; rdata = 16'h0;
    for (int i = 0; i < 7; i++) begin
      expect_wb(16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
      cycle("late_wait", 1'b1, 1'b0, 1'b1, 1'b0);
    end
    ack = 1'b1; rdata = 16'h7777;
    expect_wb(16'h7777, 4'd7, 1'b1, 1'b0, 1'b1);
    cycle("late_ack", 1'b1, 1'b0, 1'b0, 1'b0);

    // timeout: 8 request cycles with no ack, then ERROR
    set_in(16'h0030, 16'h0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    ack = 1'b0;
    for (int i = 0; i < 7; i++) begin
      expect_wb(16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
      cycle("to_wait", 1'b1, 1'b0, 1'b1, 1'b0);
    end
    expect_wb(16'h0, 4'd0, 1'b0, 1'b1, 1'b0);
    cycle("to_edge", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ack = (i == 1);
      expect_wb(16'h0, 4'd0, 1'b0, 1'b1, 1'b0);
      cycle("err_hold", 1'b0, 1'b0, 1'b1, 1'b1);
    end
    // an ALU op arriving in ERROR must not disturb the frozen state
    set_in(16'h4321, 16'h0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    ack = 1'b0;
    expect_wb(16'h0, 4'd0, 1'b0, 1'b1, 1'b0);
    cycle("err_alu", 1'b0, 1'b0, 1'b1, 1'b1);

    // reset out of ERROR
    set_in(16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_all_zero("rst_err");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // reset asserted mid-WAIT with the access still presented
    set_in(16'h0044, 16'h0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_wb(16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
      cycle("pre_rst", 1'b1, 1'b0, 1'b1, 1'b0);
    end
    rst = 1'b1;
    #1;
    check_all_zero("rst_wait");
    set_in(16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // normal operation resumes after reset
    set_in(16'h0ABC, 16'h0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_wb(16'h0ABC, 4'd10, 1'b1, 1'b0, 1'b1);
    cycle("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
